// File: rtl/binary_maxpool2d_if.sv
// Level-handshake bundle between the binary conv stage, the max-pool stage and the next layer.
// The upstream side (master) drives maps and data_in_ready; the pooling stage (slave) returns the pooled maps.
interface binary_maxpool2d_if #(
    parameter int C            = 8,
    parameter int IMG_IN_SIZE  = 28,
    parameter int IMG_OUT_SIZE = IMG_IN_SIZE / 2
);
    localparam int IN_BITS  = IMG_IN_SIZE * IMG_IN_SIZE;
    localparam int OUT_BITS = IMG_OUT_SIZE * IMG_OUT_SIZE;

    logic                data_in_ready;
    logic [IN_BITS-1:0]  img_in  [0:C-1];
    logic [OUT_BITS-1:0] img_out [0:C-1];
    logic                data_out_ready;

    modport master (
        output data_in_ready,
        output img_in,
        input  img_out,
        input  data_out_ready
    );

    modport slave (
        input  data_in_ready,
        input  img_in,
        output img_out,
        output data_out_ready
    );
endinterface

// File: rtl/binary_maxpool2d.sv
// Binary 2x2/stride-2 max-pool: each output pixel is the OR of its input window.
// One channel is pooled per clock through a shared core; data_out_ready rises once all C are stored.
module binary_maxpool2d #(
    parameter int C            = 8,
    parameter int IMG_IN_SIZE  = 28,
    parameter int IMG_OUT_SIZE = IMG_IN_SIZE / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    binary_maxpool2d_if.slave bus
);
    localparam int OUT_BITS = IMG_OUT_SIZE * IMG_OUT_SIZE;
    localparam int CH_W     = (C > 1) ? $clog2(C) : 1;
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(C - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                ready_q, ready_d;
    logic [OUT_BITS-1:0] img_out_q [0:C-1];
    logic [OUT_BITS-1:0] img_out_d [0:C-1];
    logic [OUT_BITS-1:0] pooled    [0:C-1];

    // Window taps use constant indices; an odd trailing row/column is never referenced.
    for (genvar k = 0; k < C; k++) begin : g_ch
        for (genvar r = 0; r < IMG_OUT_SIZE; r++) begin : g_row
            for (genvar c = 0; c < IMG_OUT_SIZE; c++) begin : g_col
                localparam int TL = 2 * r * IMG_IN_SIZE + 2 * c;
                assign pooled[k][r*IMG_OUT_SIZE+c] = bus.img_in[k][TL] | bus.img_in[k][TL+1] |
                                                     bus.img_in[k][TL+IMG_IN_SIZE] |
                                                     bus.img_in[k][TL+IMG_IN_SIZE+1];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        ready_d   = ready_q;
        img_out_d = img_out_q;
        if (!bus.data_in_ready) begin
            // Dropping the level aborts from any state and discards partial results.
            state_d = IDLE;
            ch_d    = '0;
            ready_d = 1'b0;
            for (int k = 0; k < C; k++) img_out_d[k] = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = RUN;
                    ch_d    = '0;
                end
                RUN: begin
                    for (int k = 0; k < C; k++) begin
                        if (ch_q == CH_W'(k)) img_out_d[k] = pooled[k];
                    end
                    if (ch_q == CH_LAST) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            ready_q <= 1'b0;
            for (int k = 0; k < C; k++) img_out_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            ready_q   <= ready_d;
            img_out_q <= img_out_d;
        end
    end

    assign bus.img_out        = img_out_q;
    assign bus.data_out_ready = ready_q;
endmodule

// File: tb/tb_binary_maxpool2d.sv
// Self-checking bench for binary_maxpool2d: default 8x28x28 instance plus a C=1, 5x5 instance.
// Expected maps come from a window-max reference model working on plain pixel coordinates.
module tb_binary_maxpool2d;
    localparam int C  = 8;
    localparam int N  = 28;
    localparam int M  = 14;
    localparam int NB = N * N;
    localparam int MB = M * M;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int vectors     = 0;
    int miscompares = 0;

    binary_maxpool2d_if #(.C(C), .IMG_IN_SIZE(N)) if8 ();
    binary_maxpool2d_if #(.C(1), .IMG_IN_SIZE(5)) if1 ();

    binary_maxpool2d #(.C(C), .IMG_IN_SIZE(N)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    binary_maxpool2d #(.C(1), .IMG_IN_SIZE(5)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    logic [NB-1:0] src  [0:C-1];
    logic [MB-1:0] exp8 [0:C-1];

    // Output (r,c) is the maximum pixel over rows 2r..2r+1, columns 2c..2c+1 of an n x n map.
    function automatic logic [MB-1:0] ref_pool(input logic [NB-1:0] img, input int n);
        logic [MB-1:0] res;
        logic [NB-1:0] px;
        int m, best;
        res = '0;
        m = n / 2;
        for (int r = 0; r < m; r++)
            for (int c = 0; c < m; c++) begin
                best = 0;
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++) begin
                        px = img >> ((2 * r + dr) * n + 2 * c + dc);
                        if (int'(px[0]) > best) best = int'(px[0]);
                    end
                if (best == 1) res = res | (MB'(1) << (r * m + c));
            end
        return res;
    endfunction

    function automatic logic [NB-1:0] rand_img(input int bits, input int sparsity);
        logic [NB-1:0] img;
        img = '0;
        for (int i = 0; i < bits; i++)
            if ($urandom_range(0, sparsity) == 0) img = img | (NB'(1) << i);
        return img;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load8();
        for (int k = 0; k < C; k++) begin
            if8.img_in[k] = src[k];
            exp8[k] = ref_pool(src[k], N);
        end
    endtask

    task automatic test_reset();
        logic [NB-1:0] t;
        rst_n = 1'b0;
        for (int k = 0; k < C; k++) src[k] = rand_img(NB, 1);
        load8();
        t = rand_img(25, 1);
        if1.img_in[0] = t[24:0];
        if8.data_in_ready = 1'b1;
        if1.data_in_ready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            step();
            vectors++;
            if (if8.data_out_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_ready cyc%0d: got %b expected 0", cyc, if8.data_out_ready);
            end
            for (int k = 0; k < C; k++) begin
                vectors++;
                if (if8.img_out[k] !== '0) begin
                    miscompares++;
                    $display("FAIL reset_out ch%0d: got %h expected 0", k, if8.img_out[k]);
                end
            end
            vectors++;
            if (if1.data_out_ready !== 1'b0 || if1.img_out[0] !== 4'h0) begin
                miscompares++;
                $display("FAIL reset_c1: got rdy=%b out=%h expected 0/0", if1.data_out_ready, if1.img_out[0]);
            end
        end
        if8.data_in_ready = 1'b0;
        if1.data_in_ready = 1'b0;
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_pixel();
        for (int k = 0; k < C; k++) src[k] = '0;
        src[0] = NB'(1) << (3 * N + 5);
        load8();
        if8.data_in_ready = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step();
            vectors++;
            if (if8.data_out_ready !== (e == 9)) begin
                miscompares++;
                $display("FAIL pixel_ready edge%0d: got %b expected %b", e, if8.data_out_ready, e == 9);
            end
        end
        vectors++;
        if (if8.img_out[0] !== (MB'(1) << (1 * M + 2))) begin
            miscompares++;
            $display("FAIL pixel_ch0: got %h expected %h", if8.img_out[0], MB'(1) << (1 * M + 2));
        end
        for (int k = 1; k < C; k++) begin
            vectors++;
            if (if8.img_out[k] !== '0) begin
                miscompares++;
                $display("FAIL pixel_ch%0d: got %h expected 0", k, if8.img_out[k]);
            end
        end
        if8.data_in_ready = 1'b0;
        step();
    endtask

    task automatic test_patterns();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < C; k++) begin
                src[k] = '0;
                if (p == 0)
                    for (int i = 0; i < NB; i++)
                        if (((i / N) + (i % N)) % 2 == 1) src[k] = src[k] | (NB'(1) << i);
            end
            load8();
            if8.data_in_ready = 1'b1;
            repeat (9) step();
            vectors++;
            if (if8.data_out_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL pattern%0d_ready: got %b expected 1", p, if8.data_out_ready);
            end
            for (int k = 0; k < C; k++) begin
                vectors++;
                if (if8.img_out[k] !== ((p == 0) ? {MB{1'b1}} : {MB{1'b0}}) || if8.img_out[k] !== exp8[k]) begin
                    miscompares++;
                    $display("FAIL pattern%0d_ch%0d: got %h expected %h", p, k, if8.img_out[k], exp8[k]);
                end
            end
            if8.data_in_ready = 1'b0;
            step();
        end
    endtask

    task automatic test_random_progressive();
        for (int run = 0; run < 3; run++) begin
            for (int k = 0; k < C; k++) src[k] = rand_img(NB, 2 + 3 * run);
            load8();
            if8.data_in_ready = 1'b1;
            for (int e = 1; e <= 11; e++) begin
                step();
                vectors++;
                if (if8.data_out_ready !== (e >= 9)) begin
                    miscompares++;
                    $display("FAIL rand%0d_ready edge%0d: got %b expected %b", run, e, if8.data_out_ready, e >= 9);
                end
                for (int k = 0; k < C; k++) begin
                    vectors++;
                    if (if8.img_out[k] !== ((k + 2 <= e) ? exp8[k] : '0)) begin
                        miscompares++;
                        $display("FAIL rand%0d_edge%0d_ch%0d: got %h expected %h", run, e, k,
                                 if8.img_out[k], (k + 2 <= e) ? exp8[k] : '0);
                    end
                end
            end
            if8.data_in_ready = 1'b0;
            step();
        end
    endtask

    task automatic test_abort();
        for (int k = 0; k < C; k++) src[k] = rand_img(NB, 1);
        load8();
        if8.data_in_ready = 1'b1;
        repeat (4) step();
        if8.data_in_ready = 1'b0;
        step();
        vectors++;
        if (if8.data_out_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_ready: got %b expected 0", if8.data_out_ready);
        end
        for (int k = 0; k < C; k++) begin
            vectors++;
            if (if8.img_out[k] !== '0) begin
                miscompares++;
                $display("FAIL abort_clear ch%0d: got %h expected 0", k, if8.img_out[k]);
            end
        end
        step();
        for (int k = 0; k < C; k++) src[k] = rand_img(NB, 4);
        load8();
        if8.data_in_ready = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step();
            vectors++;
            if (if8.data_out_ready !== (e == 9)) begin
                miscompares++;
                $display("FAIL abort_rerun_ready edge%0d: got %b expected %b", e, if8.data_out_ready, e == 9);
            end
        end
        for (int k = 0; k < C; k++) begin
            vectors++;
            if (if8.img_out[k] !== exp8[k]) begin
                miscompares++;
                $display("FAIL abort_rerun ch%0d: got %h expected %h", k, if8.img_out[k], exp8[k]);
            end
        end
        if8.data_in_ready = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < C; k++) src[k] = rand_img(NB, 1);
        load8();
        if8.data_in_ready = 1'b1;
        repeat (7) step();
        vectors++;
        if (if8.img_out[5] !== exp8[5]) begin
            miscompares++;
            $display("FAIL areset_pre ch5: got %h expected %h", if8.img_out[5], exp8[5]);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (if8.data_out_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_ready: got %b expected 0", if8.data_out_ready);
        end
        for (int k = 0; k < C; k++) begin
            vectors++;
            if (if8.img_out[k] !== '0) begin
                miscompares++;
                $display("FAIL areset_clear ch%0d: got %h expected 0", k, if8.img_out[k]);
            end
        end
        for (int k = 0; k < C; k++) src[k] = rand_img(NB, 3);
        load8();
        #1 rst_n = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step();
            vectors++;
            if (if8.data_out_ready !== (e == 9)) begin
                miscompares++;
                $display("FAIL areset_rerun_ready edge%0d: got %b expected %b", e, if8.data_out_ready, e == 9);
            end
        end
        for (int k = 0; k < C; k++) begin
            vectors++;
            if (if8.img_out[k] !== exp8[k]) begin
                miscompares++;
                $display("FAIL areset_rerun ch%0d: got %h expected %h", k, if8.img_out[k], exp8[k]);
            end
        end
        if8.data_in_ready = 1'b0;
        step();
    endtask

    task automatic test_c1();
        logic [NB-1:0] img;
        logic [MB-1:0] e1;
        for (int run = 0; run < 4; run++) begin
            img = '0;
            if (run == 0) begin
                for (int i = 0; i < 25; i++)
                    if ((i / 5) == 4 || (i % 5) == 4) img = img | (NB'(1) << i);
            end else begin
                img = rand_img(25, run);
            end
            e1 = ref_pool(img, 5);
            if1.img_in[0] = img[24:0];
            if1.data_in_ready = 1'b1;
            step();
            vectors++;
            if (if1.data_out_ready !== 1'b0 || if1.img_out[0] !== 4'h0) begin
                miscompares++;
                $display("FAIL c1_run%0d_edge1: got rdy=%b out=%h expected 0/0", run, if1.data_out_ready, if1.img_out[0]);
            end
            step();
            vectors++;
            if (if1.data_out_ready !== 1'b1 || if1.img_out[0] !== e1[3:0] || (run == 0 && if1.img_out[0] !== 4'h0)) begin
                miscompares++;
                $display("FAIL c1_run%0d_edge2: got rdy=%b out=%h expected 1/%h", run, if1.data_out_ready, if1.img_out[0], e1[3:0]);
            end
            if1.data_in_ready = 1'b0;
            step();
        end
    endtask

    initial begin
        if8.data_in_ready = 1'b0;
        if1.data_in_ready = 1'b0;
        for (int k = 0; k < C; k++) if8.img_in[k] = '0;
        if1.img_in[0] = '0;
        test_reset();
        test_single_pixel();
        test_patterns();
        test_random_progressive();
        test_abort();
        test_async_reset();
        test_c1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
